// File: rtl/pc_fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_pkg
//   Shared definitions for the PC / instruction-fetch sequencer.
//   - PC_W, RESET_PC : program-counter width and reset-time PC value
//   - ENC_*          : 3-bit state encodings
//   - state_t        : FSM state type built on those encodings
// ---------------------------------------------------------------------------
package pc_fetch_sequencer_pkg;

    localparam int              PC_W     = 20;
    localparam logic [PC_W-1:0] RESET_PC = 20'h00000;

    localparam logic [2:0] ENC_INIT  = 3'd0;
    localparam logic [2:0] ENC_IDLE  = 3'd1;
    localparam logic [2:0] ENC_REQ   = 3'd2;
    localparam logic [2:0] ENC_STALL = 3'd3;
    localparam logic [2:0] ENC_ERR   = 3'd4;

    typedef enum logic [2:0] {
        ST_INIT  = ENC_INIT,
        ST_IDLE  = ENC_IDLE,
        ST_REQ   = ENC_REQ,
        ST_STALL = ENC_STALL,
        ST_ERR   = ENC_ERR
    } state_t;

endpackage

// File: rtl/pc_fetch_sequencer_timeout.sv
// ---------------------------------------------------------------------------
// pc_fetch_timeout
//   Loadable TO_W-bit up-counter used to bound how long a fetch request may
//   wait for its acknowledge.
//   Ports:
//     clk      : clock, rising edge
//     rst_n    : asynchronous active-low reset (count -> 0)
//     clr      : synchronous clear (highest priority)
//     load     : synchronous load of load_val
//     load_val : value loaded when load is high
//     en       : increment by one
//     limit    : number of increments that constitutes expiry
//     expire   : high when the current count is the last one before limit,
//                i.e. this cycle's increment would reach limit
// ---------------------------------------------------------------------------
module pc_fetch_timeout #(
    parameter int TO_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [TO_W-1:0] load_val,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic            expire
);

    logic [TO_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en) begin
            cnt_reg <= cnt_reg + TO_W'(1);
        end
    end

    // Independent of en so the caller can use it inside its own next-state
    // logic without forming a combinational loop through en.
    assign expire = (cnt_reg == (limit - TO_W'(1)));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//   Drives the next-PC input of an external PC register and issues one
//   instruction-memory fetch per instruction: sequential increment, branch
//   redirect, stall, halt and a fetch-acknowledge timeout.
//   Ports:
//     clk           : clock, rising edge (shared with the PC register)
//     reset         : asynchronous active-low reset
//     start         : level, leave IDLE/ERR and begin fetching
//     halt          : level, stop after any outstanding fetch
//     stall         : level, hold PC and issue no new fetch
//     branch_valid  : 1-cycle pulse, redirect to branch_target
//     branch_target : redirect address
//     pc_cur        : PC register output
//     pc_next       : PC register input (combinational)
//     imem_req      : fetch request, held until imem_ack
//     imem_addr     : fetch address (pc_cur while imem_req, else 0)
//     imem_ack      : fetch complete this cycle
//     instr_valid   : registered pulse the cycle after a non-squashed ack
//     busy          : state is neither IDLE nor ERR
//     err           : sticky fetch timeout
// ---------------------------------------------------------------------------
module pc_fetch_sequencer
    import pc_fetch_sequencer_pkg::*;
#(
    parameter int unsigned PC_INC  = 1,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            halt,
    input  logic            stall,
    input  logic            branch_valid,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] pc_cur,
    output logic [PC_W-1:0] pc_next,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    output logic            instr_valid,
    output logic            busy,
    output logic            err
);

    localparam logic [PC_W-1:0] PC_STEP  = PC_W'(PC_INC);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    state_t          state_reg;
    state_t          state_next;
    logic            pend_valid_reg;
    logic [PC_W-1:0] pend_target_reg;
    logic            instr_valid_reg;
    logic            err_reg;

    logic            to_clr;
    logic            to_en;
    logic            to_expire;

    // A branch arriving in the ack cycle is newer than any captured target.
    logic            redirect;
    logic [PC_W-1:0] redirect_pc;

    assign redirect    = branch_valid || pend_valid_reg;
    assign redirect_pc = branch_valid ? branch_target : pend_target_reg;

    pc_fetch_timeout #(
        .TO_W(TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (reset),
        .clr     (to_clr),
        .load    (1'b0),
        .load_val('0),
        .en      (to_en),
        .limit   (TO_LIMIT),
        .expire  (to_expire)
    );

    // Next-state, next-PC and request generation.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_cur;
        imem_req   = 1'b0;
        to_clr     = 1'b0;
        to_en      = 1'b0;

        case (state_reg)
            ST_INIT: begin
                pc_next    = RESET_PC;
                state_next = ST_IDLE;
            end

            ST_IDLE: begin
                if (branch_valid) begin
                    pc_next = branch_target;
                end
                if (start && !halt) begin
                    state_next = stall ? ST_STALL : ST_REQ;
                end
            end

            ST_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    // Each new fetch gets a fresh timeout window.
                    to_clr  = 1'b1;
                    pc_next = redirect ? redirect_pc : (pc_cur + PC_STEP);
                    if (halt) begin
                        state_next = ST_IDLE;
                    end else if (stall) begin
                        state_next = ST_STALL;
                    end else begin
                        state_next = ST_REQ;
                    end
                end else begin
                    to_en = 1'b1;
                    if (to_expire) begin
                        to_clr     = 1'b1;
                        state_next = ST_ERR;
                    end
                end
            end

            ST_STALL: begin
                if (branch_valid) begin
                    pc_next = branch_target;
                end
                if (!stall) begin
                    state_next = halt ? ST_IDLE : ST_REQ;
                end
            end

            ST_ERR: begin
                if (start) begin
                    state_next = ST_REQ;
                end
            end

            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_INIT;
            pend_valid_reg  <= 1'b0;
            pend_target_reg <= '0;
            instr_valid_reg <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            instr_valid_reg <= (state_reg == ST_REQ) && imem_ack && !redirect;

            // The pending redirect only lives while a request is still
            // waiting; any ack, timeout or REQ exit consumes/drops it.
            if ((state_reg == ST_REQ) && !imem_ack && !to_expire) begin
                if (branch_valid) begin
                    pend_valid_reg  <= 1'b1;
                    pend_target_reg <= branch_target;
                end
            end else begin
                pend_valid_reg <= 1'b0;
            end

            if ((state_reg == ST_REQ) && !imem_ack && to_expire) begin
                err_reg <= 1'b1;
            end else if ((state_reg == ST_ERR) && start) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign imem_addr   = imem_req ? pc_cur : '0;
    assign instr_valid = instr_valid_reg;
    assign err         = err_reg;
    assign busy        = (state_reg != ST_IDLE) && (state_reg != ST_ERR);

endmodule
